// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder pipeline arbiter.
// Tag width is sized for the largest supported requester count; modules narrow it.
package adder_arb_pkg;

   localparam int unsigned C_NUM_REQ_MAX = 16;
   localparam int unsigned C_TAG_WIDTH   = $clog2(C_NUM_REQ_MAX);

   function automatic logic [C_TAG_WIDTH-1:0] onehot_to_idx(input logic [C_NUM_REQ_MAX-1:0] oh);
      logic [C_TAG_WIDTH-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < C_NUM_REQ_MAX; i++) begin
         if (oh[C_TAG_WIDTH'(i)]) idx = C_TAG_WIDTH'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/adder_pipeline_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer one past the winner whenever a grant is taken.
module rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned C_NUM_REQ = 4
)(
   input  logic                 iclk,
   input  logic                 irst_n,
   input  logic [C_NUM_REQ-1:0] req,
   input  logic                 advance,
   output logic [C_NUM_REQ-1:0] grant
);

   localparam int unsigned C_PW = $clog2(C_NUM_REQ);

   logic [C_PW-1:0] ptr;
   logic [C_PW-1:0] ptr_nxt;
   logic [C_PW-1:0] gidx;
   int unsigned     idx;
   logic            found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
         idx = (32'(ptr) + i) % C_NUM_REQ;
         if (!found && req[C_PW'(idx)]) begin
            grant[C_PW'(idx)] = 1'b1;
            found             = 1'b1;
         end
      end
   end

   always_comb begin
      gidx    = C_PW'(onehot_to_idx(C_NUM_REQ_MAX'(grant)));
      ptr_nxt = (32'(gidx) == C_NUM_REQ - 1) ? '0 : gidx + 1'b1;
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/adder_pipeline_arbiter.sv
// Shares one external adder pipeline among several requesters; the winner's tag
// travels beside the operation and steers the registered result back to it.
module adder_pipeline_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned C_OPERAND_WIDTH = 3,
   parameter int unsigned C_NUM_REQ       = 4,
   parameter int unsigned C_ADDER_LATENCY = 2
)(
   input  logic                                 iclk,
   input  logic                                 irst_n,
   input  logic [C_NUM_REQ-1:0]                 i_req_valid,
   input  logic [C_NUM_REQ*C_OPERAND_WIDTH-1:0] i_req_a,
   input  logic [C_NUM_REQ*C_OPERAND_WIDTH-1:0] i_req_b,
   output logic [C_NUM_REQ-1:0]                 o_req_ready,
   output logic [C_OPERAND_WIDTH-1:0]           o_add_a,
   output logic [C_OPERAND_WIDTH-1:0]           o_add_b,
   input  logic [C_OPERAND_WIDTH:0]             i_add_r,
   output logic [C_NUM_REQ-1:0]                 o_rsp_valid,
   output logic [C_OPERAND_WIDTH:0]             o_rsp_data,
   output logic                                 o_busy
);

   localparam int unsigned W    = C_OPERAND_WIDTH;
   localparam int unsigned C_TW = $clog2(C_NUM_REQ);
   localparam int unsigned L    = C_ADDER_LATENCY;

   logic [C_NUM_REQ-1:0]       grant;
   logic [W-1:0]               sel_a;
   logic [W-1:0]               sel_b;
   logic [C_TW-1:0]            gidx;

   // Issue stage pairs with o_add_*; the L delay stages behind it line up with i_add_r.
   logic                       iss_v;
   logic [C_TW-1:0]            iss_tag;
   logic [L-1:0]               dly_v;
   logic [L-1:0][C_TW-1:0]     dly_tag;

   rr_arbiter #(
      .C_NUM_REQ (C_NUM_REQ)
   ) u_arb (
      .iclk    (iclk),
      .irst_n  (irst_n),
      .req     (i_req_valid),
      .advance (|o_req_ready),
      .grant   (grant)
   );

   always_comb begin
      o_req_ready = irst_n ? grant : '0;
      sel_a       = '0;
      sel_b       = '0;
      for (int unsigned k = 0; k < C_NUM_REQ; k++) begin
         if (grant[C_TW'(k)]) begin
            sel_a = i_req_a[k*W +: W];
            sel_b = i_req_b[k*W +: W];
         end
      end
      gidx = C_TW'(onehot_to_idx(C_NUM_REQ_MAX'(grant)));
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         o_add_a     <= '0;
         o_add_b     <= '0;
         iss_v       <= 1'b0;
         iss_tag     <= '0;
         dly_v       <= '0;
         dly_tag     <= '0;
         o_rsp_valid <= '0;
         o_rsp_data  <= '0;
      end else begin
         if (|o_req_ready) begin
            o_add_a <= sel_a;
            o_add_b <= sel_b;
         end
         iss_v       <= |o_req_ready;
         iss_tag     <= gidx;
         dly_v       <= L'({dly_v, iss_v});
         dly_tag     <= (L*C_TW)'({dly_tag, iss_tag});
         o_rsp_valid <= dly_v[L-1] ? (C_NUM_REQ'(1) << dly_tag[L-1]) : '0;
         if (dly_v[L-1]) begin
            o_rsp_data <= i_add_r;
         end
      end
   end

   assign o_busy = iss_v | (|dly_v) | (|o_rsp_valid);

endmodule

// File: tb/tb_adder_pipeline_arbiter.sv
// Directed and soak checks of adder_pipeline_arbiter against a 2-stage adder and
// an issue-order scoreboard carrying the due cycle of every accepted operation.
module tb_adder_pipeline_arbiter;

   localparam int unsigned W   = 3;
   localparam int unsigned N   = 4;
   localparam int unsigned LAT = 2;

   typedef struct {
      int         tag;
      int         due;
      logic [W:0] sum;
   } exp_t;

   logic           iclk = 1'b0;
   logic           irst_n;
   logic [N-1:0]   i_req_valid;
   logic [N*W-1:0] i_req_a;
   logic [N*W-1:0] i_req_b;
   logic [N-1:0]   o_req_ready;
   logic [W-1:0]   o_add_a;
   logic [W-1:0]   o_add_b;
   logic [W:0]     i_add_r;
   logic [N-1:0]   o_rsp_valid;
   logic [W:0]     o_rsp_data;
   logic           o_busy;

   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;
   int   ptr_m = 0;
   exp_t q[$];

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;

   // Stand-in adder pipeline: sum registered LAT times after o_add_* is sampled.
   logic [W:0] pipe [LAT];
   always_ff @(posedge iclk) begin
      pipe[0] <= {1'b0, o_add_a} + {1'b0, o_add_b};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign i_add_r = pipe[LAT-1];

   adder_pipeline_arbiter #(
      .C_OPERAND_WIDTH (W),
      .C_NUM_REQ       (N),
      .C_ADDER_LATENCY (LAT)
   ) dut (
      .iclk        (iclk),
      .irst_n      (irst_n),
      .i_req_valid (i_req_valid),
      .i_req_a     (i_req_a),
      .i_req_b     (i_req_b),
      .o_req_ready (o_req_ready),
      .o_add_a     (o_add_a),
      .o_add_b     (o_add_b),
      .i_add_r     (i_add_r),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_data  (o_rsp_data),
      .o_busy      (o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [N*W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
      return {W'(e3), W'(e2), W'(e1), W'(e0)};
   endfunction

   // One clock: check registered outputs, drive new inputs, check the grant.
   task automatic step(input logic rn, input logic [N-1:0] v,
                       input logic [N*W-1:0] a, input logic [N*W-1:0] b);
      logic [N-1:0] exp_rv;
      logic [N-1:0] eg;
      int           tag;
      exp_t         e;
      @(negedge iclk);
      exp_rv = '0;
      chk("busy", 32'(o_busy), 32'(q.size() != 0));
      if (q.size() != 0 && q[0].due == cyc) exp_rv = N'(1) << q[0].tag;
      chk("rsp_valid", 32'(o_rsp_valid), 32'(exp_rv));
      if (exp_rv != '0) begin
         chk("rsp_data", 32'(o_rsp_data), 32'(q[0].sum));
         void'(q.pop_front());
      end
      irst_n      = rn;
      i_req_valid = v;
      i_req_a     = a;
      i_req_b     = b;
      eg  = '0;
      tag = 0;
      if (!rn) begin
         q.delete();
         ptr_m = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr_m + i) % N;
            if (eg == '0 && v[j]) begin
               eg  = N'(1) << j;
               tag = j;
            end
         end
      end
      #1;
      chk("ready", 32'(o_req_ready), 32'(eg));
      if (eg != '0) begin
         e.tag = tag;
         e.due = cyc + LAT + 2;
         e.sum = (W+1)'(a[tag*W +: W]) + (W+1)'(b[tag*W +: W]);
         q.push_back(e);
         ptr_m = (tag + 1) % N;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0);
   endtask

   logic [N-1:0] t3_grants [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000};

   initial begin
      irst_n      = 1'b0;
      i_req_valid = '0;
      i_req_a     = '0;
      i_req_b     = '0;

      // Reset then idle
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0);
      idle(3);

      // Full contention from a freshly reset pointer
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'b1111, pk(i % 8, (i + 1) % 8, (i + 2) % 8, (i + 3) % 8),
              pk((3 * i) % 8, (3 * i + 1) % 8, (3 * i + 5) % 8, 7 - i % 8));
         chk("t3_grant", 32'(o_req_ready), 32'(t3_grants[i]));
      end
      idle(5);

      // Single op from requester 2
      step(1'b1, 4'b0100, pk(0, 0, 5, 0), pk(0, 0, 6, 0));
      chk("t2_grant", 32'(o_req_ready), 32'(4'b0100));
      idle(4);
      chk("t2_rsp_valid", 32'(o_rsp_valid), 32'(4'b0100));
      chk("t2_rsp_data", 32'(o_rsp_data), 32'(4'd11));
      idle(1);
      chk("t2_rsp_hold", 32'(o_rsp_data), 32'(4'd11));

      // Overflow and carry-out from requester 1
      step(1'b1, 4'b0010, pk(0, 7, 0, 0), pk(0, 7, 0, 0));
      idle(4);
      chk("t4_max", 32'(o_rsp_data), 32'(4'd14));
      step(1'b1, 4'b0010, pk(0, 7, 0, 0), pk(0, 1, 0, 0));
      chk("t4_grant", 32'(o_req_ready), 32'(4'b0010));
      idle(4);
      chk("t4_carry", 32'(o_rsp_data), 32'(4'd8));

      // Reset mid-flight
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0111, pk(1, 2, 3, 0), pk(4, 5, 6, 0));
      step(1'b0, 4'b1111, '0, '0);
      chk("t5_ready_in_reset", 32'(o_req_ready), 32'(0));
      for (int i = 0; i < 4; i++) begin
         step(1'b1, '0, '0, '0);
         chk("t5_no_rsp", 32'(o_rsp_valid), 32'(0));
      end
      step(1'b1, 4'b1111, pk(1, 1, 1, 1), pk(2, 2, 2, 2));
      chk("t5_ptr_zero", 32'(o_req_ready), 32'(4'b0001));
      idle(5);

      // Random soak with rare resets
      for (int i = 0; i < 40000; i++) begin
         step(($urandom_range(999) != 0), N'($urandom), (N*W)'($urandom), (N*W)'($urandom));
      end
      idle(6);
      chk("drain_empty", 32'(q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
